alu_issue_pipe: RTL and testbench
=================================

Name: alu_issue_pipe

Overview:
- Two-stage pipelined wrapper that sits directly upstream and downstream of the team's 1-bit ALU slice array.
- Accepts ALU requests (two WIDTH-bit operands plus a 4-bit ALU_control) over a valid/ready handshake.
- Decodes ALU_control into per-slice A_invert, B_invert, cin and operation, and drives WIDTH instances of alu_top.
- Builds carries from the slice p/g outputs in 4-bit lookahead groups, resolves the SLT "less" feedback, and returns a registered result with zero, cout and overflow flags.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of 4.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  request valid.
in_ready  output  1  stage 1 can accept this cycle.
src1  input  WIDTH  operand A.
src2  input  WIDTH  operand B.
ALU_control  input  4  opcode; [3]=A_invert, [2]=B_invert, [1:0]=operation.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
result  output  WIDTH  ALU result.
zero  output  1  result == 0.
cout  output  1  carry out of the MSB; 0 for AND/OR/NOR/NAND.
overflow  output  1  signed overflow for ADD/SUB; 0 otherwise.

Behaviour:
- Reset: asserting rst_n low immediately clears s1_valid and out_valid, and clears result, zero, cout and overflow to 0, regardless of the clock.
- Reset mid-operation: in-flight requests are dropped. in_ready is 1 after reset.
- Legal opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT
  - 1100 NOR
  - 1101 NAND
- Decode:
  - A_invert = ALU_control[3].
  - B_invert = ALU_control[2].
  - operation = ALU_control[1:0].
  - Carry-in of slice 0 = B_invert when operation is 2'b10 or 2'b11, else 0.
- Stage 1 register: captures src1, src2 and the decoded controls on an in_valid & in_ready transfer, and sets s1_valid.
- Stage 2 (combinational from the stage 1 register):
  - The WIDTH slices and 4-bit lookahead groups produce the per-bit carries: c[i+1] = g[i] | p[i]&c[i], with the group carry taken from group P/G.
  - The slice eq output is the half-sum used to form the sum.
  - less input is 0 for all bits except bit 0.
  - set = sum[WIDTH-1] ^ overflow_raw.
  - overflow_raw = c[WIDTH] ^ c[WIDTH-1].
  - For SLT, bit 0's less = set. The result is therefore {0..., set}, sign-correct even when the subtraction overflows.
- Output register: loads when s1_valid & (!out_valid | out_ready), and sets out_valid. It holds result and flags stable while out_valid & !out_ready.
- Flags:
  - zero = (result == 0), computed on the final result.
  - cout = c[WIDTH] for ADD/SUB/SLT, else 0.
  - overflow = overflow_raw for ADD/SUB only. It is 0 for SLT and the logic ops.
- Handshake and throughput:
  - in_ready = !s1_valid | !out_valid | out_ready.
  - Throughput is 1 request/cycle under continuous out_ready.
  - Latency is 2 cycles: a request accepted at edge N appears with out_valid at edge N+1 and is consumed at edge N+1 or later.
- Simultaneous events:
  - Accept and advance in the same cycle refill stage 1 with no bubble.
  - out_valid dropping and a new result loading in the same cycle is a normal transfer.
  - With out_ready held low, at most 2 requests are buffered. in_ready then falls to 0, and no request is lost or duplicated.
- Illegal opcodes: execute per raw decode of the bits. No special-casing unless the optional feature is enabled.

Optional Feature:
- Macro: ALU_ILLEGAL_OP_EN.
- When defined:
  - Adds an output port err (1 bit, registered alongside result, reset 0).
  - A request with an opcode outside the legal list produces result = 0, zero = 1, cout = 0, overflow = 0 and err = 1.
  - err is 0 for legal opcodes.
- When undefined: no err port; illegal opcodes execute per raw decode.

Test Plan:
- Reset with in_valid=1 held → out_valid=0, result=0, in_ready=1 while rst_n=0. The first request after release emerges 2 edges after acceptance.
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow=1, cout=0. SUB 5-5 → result 0, zero=1, cout=1.
- SLT with src1=0x80000000, src2=0x00000001 → result 1 (overflow case, sign-corrected). SLT with src1=1, src2=0xFFFFFFFF → result 0. Both give overflow flag 0.
- NOR 0xF0F0F0F0, 0x0F0F0000 → 0x00000F0F. NAND 0xFFFFFFFF, 0xFFFFFFFF → 0, zero=1.
- Backpressure: 4 back-to-back requests with out_ready=0 for 5 cycles → in_ready falls after 2 accepts. Releasing out_ready delivers all 4 in order, unchanged, one per cycle.
- With ALU_ILLEGAL_OP_EN: opcode 0011 → err=1, result=0, zero=1. The next legal ADD gives err=0.

Source files
------------

// File: rtl/alu_issue_pipe.sv
// Two-stage valid/ready wrapper around a WIDTH-bit array of 1-bit ALU slices with 4-bit carry lookahead.
// Optional build macro ALU_ILLEGAL_OP_EN adds an err output and forces illegal opcodes to a zero result.

module alu_top (
  input  logic       src1,
  input  logic       src2,
  input  logic       less,
  input  logic       A_invert,
  input  logic       B_invert,
  input  logic       cin,
  input  logic [1:0] operation,
  output logic       result,
  output logic       p,
  output logic       g,
  output logic       eq
);
  logic a, b;

  assign a  = src1 ^ A_invert;
  assign b  = src2 ^ B_invert;
  assign p  = a | b;
  assign g  = a & b;
  assign eq = a ^ b;

  always_comb begin
    result = 1'b0;
    case (operation)
      2'b00: result = a & b;
      2'b01: result = a | b;
      2'b10: result = eq ^ cin;
      2'b11: result = less;
      default: result = 1'b0;
    endcase
  end
endmodule

module alu_issue_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
`ifdef ALU_ILLEGAL_OP_EN
  ,
  output logic             err
`endif
);
  localparam int NG = WIDTH / 4;

  // Stage 1 register
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             ainv_q, ainv_d, binv_q, binv_d, cin_q, cin_d;
  logic [1:0]       op_q, op_d;
  logic             s1_valid_q, s1_valid_d;

  // Output register
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;

  logic             accept, advance;

  // Stage 2 datapath
  logic [WIDTH-1:0] slice_res, p, g, eq, less_vec;
  logic [WIDTH:0]   c;
  logic [NG-1:0]    grp_p, grp_g;
  logic             overflow_raw, sum_msb, set;

`ifdef ALU_ILLEGAL_OP_EN
  logic illegal_q, illegal_d;
  logic err_q, err_d;
`endif

  assign in_ready = !s1_valid_q || !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign advance  = s1_valid_q && (!out_valid_q || out_ready);

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    ainv_d     = ainv_q;
    binv_d     = binv_q;
    op_d       = op_q;
    cin_d      = cin_q;
    s1_valid_d = s1_valid_q;
`ifdef ALU_ILLEGAL_OP_EN
    illegal_d  = illegal_q;
`endif
    if (accept) begin
      a_d        = src1;
      b_d        = src2;
      ainv_d     = ALU_control[3];
      binv_d     = ALU_control[2];
      op_d       = ALU_control[1:0];
      cin_d      = ALU_control[2] & ALU_control[1];
      s1_valid_d = 1'b1;
`ifdef ALU_ILLEGAL_OP_EN
      case (ALU_control)
        4'b0000, 4'b0001, 4'b0010, 4'b0110,
        4'b0111, 4'b1100, 4'b1101: illegal_d = 1'b0;
        default:                   illegal_d = 1'b1;
      endcase
`endif
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      ainv_q     <= 1'b0;
      binv_q     <= 1'b0;
      op_q       <= 2'b00;
      cin_q      <= 1'b0;
      s1_valid_q <= 1'b0;
`ifdef ALU_ILLEGAL_OP_EN
      illegal_q  <= 1'b0;
`endif
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      ainv_q     <= ainv_d;
      binv_q     <= binv_d;
      op_q       <= op_d;
      cin_q      <= cin_d;
      s1_valid_q <= s1_valid_d;
`ifdef ALU_ILLEGAL_OP_EN
      illegal_q  <= illegal_d;
`endif
    end
  end

  // Only bit 0 sees the SLT feedback; all other slices get less = 0.
  assign less_vec = {{(WIDTH-1){1'b0}}, set};

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
      alu_top u_slice (
        .src1      (a_q[gi]),
        .src2      (b_q[gi]),
        .less      (less_vec[gi]),
        .A_invert  (ainv_q),
        .B_invert  (binv_q),
        .cin       (c[gi]),
        .operation (op_q),
        .result    (slice_res[gi]),
        .p         (p[gi]),
        .g         (g[gi]),
        .eq        (eq[gi])
      );
    end
  endgenerate

  // Inner carries of each group come from its carry-in; the group carry-out uses group P/G.
  always_comb begin
    c     = '0;
    grp_p = '0;
    grp_g = '0;
    c[0]  = cin_q;
    for (int k = 0; k < NG; k++) begin
      grp_p[k]    = &p[4*k +: 4];
      grp_g[k]    = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      c[4*k+1]    = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2]    = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3]    = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4]    = grp_g[k] | (grp_p[k] & c[4*k]);
    end
  end

  assign overflow_raw = c[WIDTH] ^ c[WIDTH-1];
  assign sum_msb      = eq[WIDTH-1] ^ c[WIDTH-1];
  assign set          = sum_msb ^ overflow_raw;

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
`ifdef ALU_ILLEGAL_OP_EN
    err_d       = err_q;
`endif
    if (advance) begin
      out_valid_d = 1'b1;
      result_d    = slice_res;
      cout_d      = op_q[1] ? c[WIDTH] : 1'b0;
      ovf_d       = (op_q == 2'b10) ? overflow_raw : 1'b0;
`ifdef ALU_ILLEGAL_OP_EN
      err_d       = illegal_q;
      if (illegal_q) begin
        result_d = '0;
        cout_d   = 1'b0;
        ovf_d    = 1'b0;
      end
`endif
      zero_d      = (result_d == '0);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef ALU_ILLEGAL_OP_EN
      err_q       <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
`ifdef ALU_ILLEGAL_OP_EN
      err_q       <= err_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
`ifdef ALU_ILLEGAL_OP_EN
  assign err       = err_q;
`endif
endmodule

// File: tb/tb_alu_issue_pipe.sv
// Scoreboard bench for alu_issue_pipe: directed corner cases, backpressure, resets and random traffic.
// Build with ALU_ILLEGAL_OP_EN defined to also exercise the err output.

module tb_alu_issue_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic [3:0]   ALU_control = 4'b0000;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, cout, overflow;
`ifdef ALU_ILLEGAL_OP_EN
  logic         err;
`endif

  alu_issue_pipe #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .src1        (src1),
    .src2        (src2),
    .ALU_control (ALU_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .cout        (cout),
    .overflow    (overflow)
`ifdef ALU_ILLEGAL_OP_EN
    ,
    .err         (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        c;
    logic        o;
    logic        e;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  bit   rand_rdy = 1'b0;

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0110,
                         OP_SLT = 4'b0111, OP_NOR = 4'b1100, OP_NAND = 4'b1101;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on the operation's meaning.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    exp_t        e;
    logic [32:0] s;
    longint      sa, sb, sr;
    e  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_AND:  e.r = a & b;
      OP_OR:   e.r = a | b;
      OP_NOR:  e.r = ~(a | b);
      OP_NAND: e.r = ~(a & b);
      OP_ADD: begin
        s   = {1'b0, a} + {1'b0, b};
        e.r = s[31:0];
        e.c = s[32];
        sr  = sa + sb;
        e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      OP_SUB: begin
        e.r = a - b;
        e.c = (a >= b);
        sr  = sa - sb;
        e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      OP_SLT: begin
        e.r = (sa < sb) ? 32'd1 : 32'd0;
        e.c = (a >= b);
      end
      default: begin
        e.r = 32'd0;
        e.e = 1'b1;
      end
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output got=%0h exp=none", result);
      end else begin
        mon_e = sb_q.pop_front();
        check("result", result, mon_e.r);
        check("zero", zero, mon_e.z);
        check("cout", cout, mon_e.c);
        check("overflow", overflow, mon_e.o);
`ifdef ALU_ILLEGAL_OP_EN
        check("err", err, mon_e.e);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    int t = 0;
    @(negedge clk);
    in_valid    = 1'b1;
    src1        = a;
    src2        = b;
    ALU_control = op;
    #1;
    while (!in_ready) begin
      t++;
      if (t > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout got=in_ready_low exp=accept");
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    sb_q.push_back(model(a, b, op));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [5];
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h0000_0001;
    specials[2] = 32'h7FFF_FFFF;
    specials[3] = 32'h8000_0000;
    specials[4] = 32'hFFFF_FFFF;
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  function automatic logic [3:0] pick_op();
    logic [3:0] ops [7];
    ops[0] = OP_AND; ops[1] = OP_OR;  ops[2] = OP_ADD; ops[3] = OP_SUB;
    ops[4] = OP_SLT; ops[5] = OP_NOR; ops[6] = OP_NAND;
    return ops[$urandom_range(0, 6)];
  endfunction

  logic [31:0] bp_a [4];
  logic [31:0] bp_b [4];
  logic [3:0]  bp_op [4];

  initial begin
    int k;
    int t;

    // Reset held with a valid request pending: nothing may be accepted or presented.
    rst_n       = 1'b0;
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    src1        = 32'h1234_5678;
    src2        = 32'h1111_1111;
    ALU_control = OP_ADD;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Latency: accepted at edge N, visible after edge N+1.
    @(negedge clk);
    in_valid = 1'b1; src1 = 32'd3; src2 = 32'd4; ALU_control = OP_ADD;
    #1;
    check("lat_in_ready", in_ready, 1);
    sb_q.push_back(model(32'd3, 32'd4, OP_ADD));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("lat_after_accept_edge", out_valid, 0);
    @(negedge clk);
    #1;
    check("lat_after_next_edge", out_valid, 1);
    idle(2);

    send(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD);
    send(32'd5, 32'd5, OP_SUB);
    send(32'h8000_0000, 32'h0000_0001, OP_SLT);
    send(32'h0000_0001, 32'hFFFF_FFFF, OP_SLT);
    send(32'hF0F0_F0F0, 32'h0F0F_0000, OP_NOR);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_NAND);
    send(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD);
    send(32'h8000_0000, 32'h0000_0001, OP_SUB);
    send(32'hA5A5_A5A5, 32'h0FF0_0FF0, OP_AND);
    send(32'hA5A5_A5A5, 32'h0FF0_0FF0, OP_OR);
    idle(4);

    // Backpressure: two requests buffer, the rest wait.
    for (int i = 0; i < 4; i++) begin
      bp_a[i]  = $urandom;
      bp_b[i]  = $urandom;
      bp_op[i] = pick_op();
    end
    out_ready = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      in_valid = (k < 4);
      if (k < 4) begin
        src1 = bp_a[k]; src2 = bp_b[k]; ALU_control = bp_op[k];
      end
      #1;
      if (in_valid && in_ready) begin
        sb_q.push_back(model(bp_a[k], bp_b[k], bp_op[k]));
        k++;
      end
    end
    check("bp_accepts_stalled", k, 2);
    check("bp_in_ready_stalled", in_ready, 0);
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (k < 4);
      if (k < 4) begin
        src1 = bp_a[k]; src2 = bp_b[k]; ALU_control = bp_op[k];
      end
      #1;
      if (cyc < 4) check("bp_drain_valid", out_valid, 1);
      if (in_valid && in_ready) begin
        sb_q.push_back(model(bp_a[k], bp_b[k], bp_op[k]));
        k++;
      end
    end
    check("bp_accepts_total", k, 4);
    idle(3);

    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(pick_operand(), pick_operand(), pick_op());
    end

    // Reset in the middle of buffered traffic drops everything.
    rand_rdy  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    t = 0;
    while (sb_q.size() != 0 && t < 50) begin
      @(negedge clk);
      out_ready = 1'b1;
      t++;
    end
    out_ready = 1'b0;
    send(32'd10, 32'd20, OP_ADD);
    send(32'd30, 32'd40, OP_SUB);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_in_ready", in_ready, 1);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(32'h0000_00FF, 32'h0000_0F00, OP_OR);

`ifdef ALU_ILLEGAL_OP_EN
    send(32'd5, 32'd6, 4'b0011);
    send(32'd1, 32'd2, OP_ADD);
`endif

    out_ready = 1'b1;
    t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    #3;
    check("drain_left", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
